// File: rtl/instr_issue_pkg.sv
// instr_issue_pkg: opcode, field and FSM definitions shared by the issue sequencer and decode
package instr_issue_pkg;
   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_INC = 3'b011;
   localparam int MODE_BIT = 7;
   localparam int OP_HI = 6;
   localparam int OP_LO = 4;
   localparam int RD_HI = 3;
   localparam int RD_LO = 2;
   localparam int RS2_HI = 1;
   localparam int RS2_LO = 0;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   function automatic logic writes_reg(input logic [7:0] w);
      return w[OP_HI:OP_LO] != OP_NOP;
   endfunction
   // only two physical registers: encoding 00 is R0, everything else aliases to R1
   function automatic logic eff_reg(input logic [1:0] enc);
      return enc != 2'b00;
   endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: shift register of recently issued writers, flags reads of in-flight registers
module issue_scoreboard #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic push_valid,
   input  logic push_reg,
   input  logic query_a,
   input  logic query_b,
   output logic hazard
);
   logic [DEPTH-1:0] v, r;
   function automatic logic match(input logic [DEPTH-1:0] vv, input logic [DEPTH-1:0] rr, input logic q);
      return |(vv & ~(rr ^ {DEPTH{q}}));
   endfunction
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         v <= '0;
         r <= '0;
      end else begin
         v[0] <= push_valid;
         r[0] <= push_reg;
         for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            r[i] <= r[i-1];
         end
      end
   assign hazard = match(v, r, query_a) | match(v, r, query_b);
endmodule

// File: rtl/instr_issue.sv
// instr_issue: buffered program sequencer feeding fetch, inserting NOP bubbles on RAW hazards
module instr_issue
   import instr_issue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int HAZARD_DIST = 5
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       load_valid,
   input  logic [7:0]                 load_data,
   output logic                       load_ready,
   input  logic                       clear,
   input  logic                       start,
   output logic [7:0]                 issue_instr,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(HAZARD_DIST);
   state_t state, state_n;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] pc;
   logic [DW-1:0] dcnt;
   logic [7:0] cand;
   logic hazard, stall, last, load_fire, go, push_v, drain_end;
   assign cand = mem[pc];
   assign load_ready = (state == S_IDLE) && (count < CW'(DEPTH));
   assign load_fire = load_valid && load_ready && !clear;
   assign go = start && !clear && (count != '0 || load_fire);
   assign stall = hazard && writes_reg(cand);
   assign last = CW'(pc) == count - CW'(1);
   assign push_v = (state == S_RUN) && !stall && writes_reg(cand);
   assign drain_end = dcnt == DW'(HAZARD_DIST - 1);
   issue_scoreboard #(.DEPTH(HAZARD_DIST - 1)) u_sb (
      .clk        (clk),
      .resetn     (resetn),
      .push_valid (push_v),
      .push_reg   (eff_reg(cand[RD_HI:RD_LO])),
      .query_a    (eff_reg(cand[RD_HI:RD_LO])),
      .query_b    (eff_reg(cand[RS2_HI:RS2_LO])),
      .hazard     (hazard)
   );
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = go ? S_RUN : S_IDLE;
         S_RUN:   state_n = (!stall && last) ? S_DRAIN : S_RUN;
         S_DRAIN: state_n = drain_end ? S_DONE : S_DRAIN;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= S_IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         count       <= '0;
         pc          <= '0;
         dcnt        <= '0;
         issue_instr <= 8'h00;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         if (state == S_IDLE) count <= clear ? '0 : load_fire ? count + CW'(1) : count;
         pc          <= (state == S_IDLE) ? '0 : (state == S_RUN && !stall) ? pc + AW'(1) : pc;
         dcnt        <= (state == S_DRAIN && !drain_end) ? dcnt + DW'(1) : '0;
         issue_instr <= (state == S_RUN && !stall) ? cand : 8'h00;
         busy        <= (state_n == S_RUN) || (state_n == S_DRAIN);
         done        <= state == S_DONE;
      end
   // program storage is deliberately left out of reset
   always_ff @(posedge clk)
      if (load_fire) mem[count[AW-1:0]] <= load_data;
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: randomized and directed programs checked against a timing-level issue model
module tb_instr_issue;
   localparam int HD = 5;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic load_valid = 1'b0;
   logic clear = 1'b0;
   logic start = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic load_ready, busy, done;
   logic [7:0] issue_instr;
   logic [4:0] count;
   always #5 clk = ~clk;
   instr_issue #(.DEPTH(DEPTH), .HAZARD_DIST(HD)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .clear       (clear),
      .start       (start),
      .issue_instr (issue_instr),
      .busy        (busy),
      .done        (done),
      .count       (count)
   );
   typedef struct packed {logic [7:0] w; logic b; logic d;} exp_t;
   exp_t exp_q[$];
   int tests = 0;
   int fails = 0;
   bit active = 0;
   logic busy_prev = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask
   function automatic bit wr(input logic [7:0] w);
      return w[6:4] != 3'b000;
   endfunction
   function automatic bit er(input logic [1:0] e);
      return e != 2'b00;
   endfunction
   // each word issues at the earliest cycle that is after its predecessor and HD after any matching writer
   task automatic model(input logic [7:0] p[$]);
      int t[$];
      logic [7:0] stream[$];
      int ti, last;
      foreach (p[i]) begin
         ti = (i == 0) ? 0 : t[i-1] + 1;
         if (wr(p[i]))
            for (int j = 0; j < i; j++)
               if (wr(p[j]) && (er(p[j][3:2]) == er(p[i][3:2]) || er(p[j][3:2]) == er(p[i][1:0])) && t[j] + HD > ti)
                  ti = t[j] + HD;
         t.push_back(ti);
      end
      last = t[t.size()-1];
      for (int s = 0; s <= last; s++) stream.push_back(8'h00);
      foreach (p[i]) stream[t[i]] = p[i];
      foreach (stream[i]) exp_q.push_back('{w: stream[i], b: 1'b1, d: 1'b0});
      for (int k = 1; k <= HD; k++) exp_q.push_back('{w: 8'h00, b: k < HD, d: 1'b0});
      exp_q.push_back('{w: 8'h00, b: 1'b0, d: 1'b1});
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         active = 0;
         exp_q.delete();
         busy_prev = 1'b0;
      end else begin
         if (!active && busy_prev && exp_q.size() > 0) active = 1;
         if (active) begin
            e = exp_q.pop_front();
            chk("issue", {24'h0, issue_instr}, {24'h0, e.w});
            chk("busy", {31'h0, busy}, {31'h0, e.b});
            chk("done", {31'h0, done}, {31'h0, e.d});
            if (exp_q.size() == 0) active = 0;
         end else chk("idle_done", {31'h0, done}, 0);
         busy_prev = busy;
      end
   end
   task automatic load(input logic [7:0] p[$]);
      foreach (p[i]) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data = p[i];
      end
      @(negedge clk);
      load_valid = 1'b0;
   endtask
   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_count", {27'h0, count}, 0);
   endtask
   task automatic run(input logic [7:0] p[$]);
      model(p);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", {31'h0, busy}, 1);
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         chk("run_timeout", exp_q.size(), 0);
         exp_q.delete();
         active = 0;
      end
      @(negedge clk);
   endtask
   initial begin
      logic [7:0] p[$];
      logic [7:0] big[$];
      int n;
      repeat (2) @(negedge clk);
      chk("rst_issue", {24'h0, issue_instr}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_ready", {31'h0, load_ready}, 1);
      chk("rst_count", {27'h0, count}, 0);
      resetn = 1'b1;
      p = {8'h34, 8'h11};
      load(p);
      chk("load_count", {27'h0, count}, 2);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mid_first", {24'h0, issue_instr}, 8'h34);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid_issue", {24'h0, issue_instr}, 0);
      chk("mid_busy", {31'h0, busy}, 0);
      chk("mid_count", {27'h0, count}, 0);
      chk("mid_ready", {31'h0, load_ready}, 1);
      @(negedge clk);
      resetn = 1'b1;
      load(p);
      run(p);
      run(p);
      do_clear();
      p = {8'h30, 8'h35};
      load(p);
      run(p);
      do_clear();
      p = {8'h38, 8'h15};
      load(p);
      run(p);
      do_clear();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         chk("empty_busy", {31'h0, busy}, 0);
         chk("empty_ready", {31'h0, load_ready}, 1);
         @(negedge clk);
      end
      for (int i = 0; i < 17; i++) big.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data = big[i];
         chk("full_ready", {31'h0, load_ready}, (i < 16) ? 1 : 0);
      end
      @(negedge clk);
      load_valid = 1'b0;
      chk("full_count", {27'h0, count}, 16);
      void'(big.pop_back());
      run(big);
      do_clear();
      p = {8'h31, 8'h22};
      load(p);
      @(negedge clk);
      clear = 1'b1;
      load_valid = 1'b1;
      load_data = 8'hAA;
      @(negedge clk);
      clear = 1'b0;
      load_valid = 1'b0;
      chk("clear_vs_load", {27'h0, count}, 0);
      repeat (12) begin
         do_clear();
         n = $urandom_range(1, 8);
         p.delete();
         for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
         load(p);
         chk("rand_count", {27'h0, count}, n);
         run(p);
         if ($urandom_range(0, 1) == 1) run(p);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_issue.md
# instr_issue

Program sequencer that feeds the pipeline's fetch stage in place of the slide switches. It holds a small instruction buffer that is filled through a valid/ready load port. On `start` it issues one 8-bit instruction word per clock toward `instr_fetch`. The pipeline has no forwarding, so the block inserts NOP bubbles (opcode 000) whenever an instruction would read a register that an in-flight instruction has not yet written back.

## Interface
Parameters:
- `DEPTH`, 16: program buffer entries (power of two, 2..256).
- `HAZARD_DIST`, 5: minimum issue-cycle distance between a writer and a dependent reader.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  a load word is offered.
- `load_data`  in  8  instruction word to append to the buffer.
- `load_ready`  out  1  buffer accepts a word this cycle.
- `clear`  in  1  empty the buffer (IDLE only).
- `start`  in  1  begin issuing the buffered program.
- `issue_instr`  out  8  instruction word driven to fetch (registered).
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the program has fully drained.
- `count`  out  $clog2(DEPTH)+1  number of buffered instructions.

## Operation
- Instruction fields: `[7]` mode, `[6:4]` opcode, `[3:2]` rd/rs1, `[1:0]` rs2.
- An instruction writes a register iff opcode != 000. Destination is `[3:2]`.
- Sources are `[3:2]` and `[1:0]`. Both are checked for every non-NOP instruction.
- Register compare uses the effective register: enc 00 maps to R0, any other enc maps to R1.
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `load_ready = (count < DEPTH)`.
  - On `load_valid && load_ready`, write `buffer[count]` and increment `count`.
  - `clear` sets `count` to 0. It takes priority over a simultaneous load.
  - `start` with `count > 0` moves to RUN with `pc = 0`.
  - `start` with `count == 0` is ignored.
  - If `start` and `load_valid` arrive together, the load is accepted and RUN begins; the new word is included.
- RUN:
  - Candidate instruction is `buffer[pc]`.
  - If any valid scoreboard entry matches a candidate source register, `issue_instr <= 8'h00` and `pc` holds.
  - Otherwise `issue_instr <= buffer[pc]` and `pc` increments.
  - After issuing the instruction at `pc == count-1`, go to DRAIN.
  - `load_ready = 0`. `clear` and `start` are ignored.
- Scoreboard:
  - Shift register of `HAZARD_DIST-1` entries, each {valid, reg}. It shifts every cycle in every state.
  - Entry 0 receives {writes, effective rd} of the word being registered into `issue_instr`. Bubbles and NOPs shift in valid=0.
- DRAIN:
  - Issue `8'h00` for `HAZARD_DIST` cycles, counted by the drain counter, then go to DONE.
- DONE:
  - `done = 1` for one cycle, then return to IDLE.
  - Buffer contents and `count` are retained, so `start` re-runs the program.
- Reset, including mid-RUN:
  - Clears the FSM to IDLE and sets `count`, `pc`, the drain counter and all scoreboard valids to 0.
  - `issue_instr = 8'h00`, `busy = 0`, `done = 0`, `load_ready = 1`.
  - Buffer RAM contents are not reset.

## Timing
- `issue_instr` is registered. A word selected in cycle t appears at t+1. Fetch captures it at the next edge.
- Dependent instructions on `issue_instr` are at least `HAZARD_DIST` cycles apart, i.e. 4 NOPs between them at the default. This covers ID, EX, MEM and WB stages plus the registered write-back into the register file.
- Independent instructions issue back-to-back, one per cycle.
- First issue appears 2 cycles after the `start` edge: 1 cycle to enter RUN, 1 cycle of output register.
- `done` asserts exactly `HAZARD_DIST+1` cycles after the last real instruction appears on `issue_instr`.
- `busy` is registered. It is high from the first RUN cycle through the last DRAIN cycle.

## Structure
- Shared package holds:
  - Opcode constants `OP_NOP=3'b000`, `OP_ADD=3'b001`, `OP_INC=3'b011`.
  - Field position constants.
  - The FSM state encoding.
  - The `writes_reg` and effective-register function used here and by the decode stage.
- One sub-module, `issue_scoreboard`:
  - Shift register plus a match function.
  - Inputs: push valid/reg and two query regs.
  - Output: hazard.
- The buffer is an inferred register array in the top.

## Test plan
- Reset mid-RUN:
  - Load {0x34, 0x11}, start, then assert `resetn=0` on the 2nd issue cycle.
  - Expect `issue_instr=0x00`, `busy=0`, `count=0`, `load_ready=1` immediately, before any clock edge.
- RAW hazard:
  - Load {0x34 (INC R1), 0x11 (ADD R0,R0,R1)}, start.
  - Expect `issue_instr` sequence 0x34, 00, 00, 00, 00, 0x11, then 5×00.
  - Then `done` pulses once and `busy` falls.
- Independent instructions:
  - Load {0x30 (INC R0), 0x35 (INC R1, rs2=R1)}, start.
  - Expect 0x30 and 0x35 on consecutive cycles with no bubbles.
- Effective-register aliasing:
  - Load {0x38 (INC, rd enc 10), 0x15 (reads enc 01)}.
  - Expect 4 NOP bubbles, because enc 10 and enc 01 both map to R1.
- Full and clear:
  - Offer 17 words with `DEPTH=16`.
  - Expect `load_ready` to drop after 16 words and `count=16`; the 17th word is not written.
  - `clear` together with `load_valid` gives `count=0`.
- Re-run and empty start:
  - After `done`, pulse `start` again; the identical issue sequence repeats.
  - `start` with `count=0` keeps the FSM in IDLE and `busy=0`.
